// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard controller.
//   - FSM state encoding (RUN / MEM_WAIT / DRAIN)
//   - NOP instruction encoding loaded by a flushed IF/ID register
//   - counter widths sized for the full legal ranges of MEM_TIMEOUT
//     (2..1023) and DRAIN_CYCLES (1..7)
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2
    } hz_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int MEM_TIMEOUT_MAX  = 1023;
    localparam int DRAIN_CYCLES_MAX = 7;

    // Wide enough to hold MEM_TIMEOUT-1 / DRAIN_CYCLES-1 for any legal value.
    localparam int MEM_CNT_W   = $clog2(MEM_TIMEOUT_MAX + 1);
    localparam int DRAIN_CNT_W = $clog2(DRAIN_CYCLES_MAX + 1);

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator.
//   in : id_rs, id_rt    source register fields of the ID instruction
//   in : id_uses_rt      ID instruction reads rt as a source
//   in : ex_mem_read     EX holds a load
//   in : ex_rt           load destination register
//   out: lu_hazard       ID must stall one cycle behind the load
// Register 0 is hard-wired zero, so a load targeting it never interlocks.
module load_use_detect (
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       lu_hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match  = (ex_rt == id_rs);
    assign rt_match  = id_uses_rt && (ex_rt == id_rt);
    assign lu_hazard = ex_mem_read && (ex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage MIPS pipeline.
//   Parameters: MEM_TIMEOUT (2..1023) watchdog limit in MEM_WAIT,
//               DRAIN_CYCLES (1..7) bubble cycles after an exception.
//   Inputs : clk, reset (async, active-high), id_rs, id_rt, id_uses_rt,
//            id_jump, ex_mem_read, ex_rt, ex_branch_taken, exc_req,
//            mem_req, mem_ready
//   Outputs: pc_en, ifid_en, ifid_flush, idex_en, idex_ctrl_en, exmem_en
//            (Mealy, from state + current inputs), mem_timeout_err
//            (registered pulse), state (debug).
//   Optional macro HAZARD_STATS_EN adds saturating counters stat_stall,
//   stat_flush and stat_memwait.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_jump,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    input  logic       exc_req,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_en,
    output logic       idex_ctrl_en,
    output logic       exmem_en,
    output logic       mem_timeout_err,
    output logic [1:0] state
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stat_stall,
    output logic [31:0] stat_flush,
    output logic [31:0] stat_memwait
`endif
);

    localparam logic [MEM_CNT_W-1:0]   MEM_LAST   = MEM_CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    hz_state_t              state_reg, state_next;
    logic [MEM_CNT_W-1:0]   mem_cnt_reg, mem_cnt_next;
    logic [DRAIN_CNT_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic                   timeout_reg, timeout_next;
    logic                   lu_hazard;
    logic                   freeze;

    load_use_detect u_lu (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .lu_hazard   (lu_hazard)
    );

    assign freeze = mem_req && !mem_ready;

    always_comb begin
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        ifid_flush     = 1'b0;
        idex_en        = 1'b1;
        idex_ctrl_en   = 1'b1;
        exmem_en       = 1'b1;
        state_next     = state_reg;
        mem_cnt_next   = mem_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        timeout_next   = 1'b0;
        // While reset is held the outputs must show reset values even if a
        // memory stall is still being requested.
        if (!reset) begin
            case (state_reg)
                RUN: begin
                    if (freeze) begin
                        {pc_en, ifid_en, idex_en, idex_ctrl_en, exmem_en} = '0;
                        state_next   = MEM_WAIT;
                        mem_cnt_next = '0;
                    end else if (exc_req) begin
                        ifid_flush     = 1'b1;
                        idex_ctrl_en   = 1'b0;
                        state_next     = DRAIN;
                        drain_cnt_next = '0;
                    end else if (ex_branch_taken) begin
                        // Also squashes any load-use in ID: no stall needed.
                        ifid_flush   = 1'b1;
                        idex_ctrl_en = 1'b0;
                    end else if (lu_hazard) begin
                        pc_en        = 1'b0;
                        ifid_en      = 1'b0;
                        idex_ctrl_en = 1'b0;
                    end else if (id_jump) begin
                        ifid_flush = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_next   = RUN;
                        mem_cnt_next = '0;
                    end else if (mem_cnt_reg == MEM_LAST) begin
                        // Watchdog: release the pipeline and report.
                        timeout_next = 1'b1;
                        state_next   = RUN;
                        mem_cnt_next = '0;
                    end else begin
                        {pc_en, ifid_en, idex_en, idex_ctrl_en, exmem_en} = '0;
                        mem_cnt_next = mem_cnt_reg + MEM_CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (freeze) begin
                        // Frozen: drain counter holds its value.
                        {pc_en, ifid_en, idex_en, idex_ctrl_en, exmem_en} = '0;
                    end else begin
                        ifid_flush   = 1'b1;
                        idex_ctrl_en = 1'b0;
                        if (exc_req) begin
                            drain_cnt_next = '0;
                        end else if (drain_cnt_reg == DRAIN_LAST) begin
                            state_next     = RUN;
                            drain_cnt_next = '0;
                        end else begin
                            drain_cnt_next = drain_cnt_reg + DRAIN_CNT_W'(1);
                        end
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= RUN;
            mem_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mem_cnt_reg   <= mem_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            timeout_reg   <= timeout_next;
        end
    end

    assign mem_timeout_err = timeout_reg;
    assign state           = state_reg;

`ifdef HAZARD_STATS_EN
    logic        stall_evt, flush_evt, memwait_evt;
    logic [31:0] stat_stall_reg, stat_flush_reg, stat_memwait_reg;

    assign stall_evt   = (state_reg == RUN) && !freeze && !exc_req &&
                         !ex_branch_taken && lu_hazard;
    // A jump behind a load-use stall is not taken that cycle.
    assign flush_evt   = ((state_reg == RUN) && !freeze &&
                          (exc_req || ex_branch_taken || (id_jump && !lu_hazard))) ||
                         ((state_reg == DRAIN) && !freeze && exc_req);
    assign memwait_evt = (state_reg == MEM_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_stall_reg   <= '0;
            stat_flush_reg   <= '0;
            stat_memwait_reg <= '0;
        end else begin
            if (stall_evt && (stat_stall_reg != '1))
                stat_stall_reg <= stat_stall_reg + 32'd1;
            if (flush_evt && (stat_flush_reg != '1))
                stat_flush_reg <= stat_flush_reg + 32'd1;
            if (memwait_evt && (stat_memwait_reg != '1))
                stat_memwait_reg <= stat_memwait_reg + 32'd1;
        end
    end

    assign stat_stall   = stat_stall_reg;
    assign stat_flush   = stat_flush_reg;
    assign stat_memwait = stat_memwait_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench for pipeline_hazard_ctrl
// (MEM_TIMEOUT=8, DRAIN_CYCLES=2). A behavioural model tracks the
// controller mode and remaining drain/wait budget and is compared against
// the DUT on every falling edge; directed steps carry literal expectations.
module tb_pipeline_hazard_ctrl;

    localparam int TO = 8;
    localparam int DC = 2;

    // Output pattern: {pc_en, ifid_en, ifid_flush, idex_en, idex_ctrl_en, exmem_en}
    localparam logic [5:0] P_DEF   = 6'b110111;
    localparam logic [5:0] P_FRZ   = 6'b000000;
    localparam logic [5:0] P_FLUSH = 6'b111101;
    localparam logic [5:0] P_STALL = 6'b000101;
    localparam logic [5:0] P_JUMP  = 6'b111111;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       jump;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       br;
        logic       exc;
        logic       mreq;
        logic       mrdy;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    vec_t       vin = '0;
    logic       pc_en, ifid_en, ifid_flush, idex_en, idex_ctrl_en, exmem_en;
    logic       mem_timeout_err;
    logic [1:0] state;
    logic [5:0] outs;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .DRAIN_CYCLES(DC)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (vin.rs),
        .id_rt           (vin.rt),
        .id_uses_rt      (vin.uses_rt),
        .id_jump         (vin.jump),
        .ex_mem_read     (vin.mem_read),
        .ex_rt           (vin.ex_rt),
        .ex_branch_taken (vin.br),
        .exc_req         (vin.exc),
        .mem_req         (vin.mreq),
        .mem_ready       (vin.mrdy),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_ctrl_en    (idex_ctrl_en),
        .exmem_en        (exmem_en),
        .mem_timeout_err (mem_timeout_err),
        .state           (state)
    );

    assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_ctrl_en, exmem_en};

    function automatic void chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got state=%0d err=%b outs=%b, need state=%0d err=%b outs=%b @%0t",
                     nm, act[8:7], act[6], act[5:0], exp[8:7], exp[6], exp[5:0], $time);
        end
    endfunction

    function automatic logic [8:0] ex(input int s, input bit e, input logic [5:0] o);
        return {2'(s), e, o};
    endfunction

    function automatic vec_t mk(input int rs, input int rt, input bit uses_rt, input bit jump,
                                input bit mem_read, input int ex_rt, input bit br,
                                input bit exc, input bit mreq, input bit mrdy);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses_rt; v.jump = jump;
        v.mem_read = mem_read; v.ex_rt = 5'(ex_rt); v.br = br; v.exc = exc;
        v.mreq = mreq; v.mrdy = mrdy;
        return v;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int   m_mode = 0;      // 0 running, 1 waiting on memory, 2 draining
    int   m_waited = 0;    // wait-state cycles already spent without ready
    int   m_left = 0;      // drain cycles still owed
    bit   m_err = 1'b0;    // watchdog fired last cycle

    always @(negedge clk) begin
        bit         stuck, lu, fire;
        logic [5:0] eo;
        stuck = vin.mreq && !vin.mrdy;
        lu = vin.mem_read && (vin.ex_rt != 0) &&
             ((vin.ex_rt == vin.rs) || (vin.uses_rt && vin.ex_rt == vin.rt));
        fire = 1'b0;
        eo = P_DEF;
        if (reset) begin
            m_mode = 0; m_waited = 0; m_left = 0; m_err = 1'b0;
        end else if (m_mode == 0) begin
            if (stuck)             eo = P_FRZ;
            else if (vin.exc)      eo = P_FLUSH;
            else if (vin.br)       eo = P_FLUSH;
            else if (lu)           eo = P_STALL;
            else if (vin.jump)     eo = P_JUMP;
        end else if (m_mode == 1) begin
            if (!vin.mrdy && m_waited == TO - 1) fire = 1'b1;
            else if (!vin.mrdy)                  eo = P_FRZ;
        end else begin
            eo = stuck ? P_FRZ : P_FLUSH;
        end

        chk("model_cycle", {state, mem_timeout_err, outs}, ex(m_mode, m_err, eo));

        if (!reset) begin
            m_err = fire;
            case (m_mode)
                0: begin
                    if (stuck)        begin m_mode = 1; m_waited = 0; end
                    else if (vin.exc) begin m_mode = 2; m_left = DC; end
                end
                1: begin
                    if (vin.mrdy || fire) m_mode = 0;
                    else                  m_waited++;
                end
                default: begin
                    if (!stuck) begin
                        if (vin.exc) m_left = DC;
                        else begin
                            m_left--;
                            if (m_left == 0) m_mode = 0;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- directed stimulus with literal expectations ----------
    task automatic step(input string nm, input vec_t v, input logic [8:0] exp);
        vin = v;
        #2;
        chk(nm, {state, mem_timeout_err, outs}, exp);
        $display("txn %-10s state=%0d err=%b outs=%b", nm, state, mem_timeout_err, outs);
        @(posedge clk);
        #1;
    endtask

    vec_t idle, wait_v;

    initial begin
        idle   = '0;
        wait_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        chk("reset_vals", {state, mem_timeout_err, outs}, ex(0, 0, P_DEF));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        step("idle", idle, ex(0, 0, P_DEF));
        // load-use on rs, then defaults again
        step("lu_rs", mk(8, 0, 0, 0, 1, 8, 0, 0, 0, 0), ex(0, 0, P_STALL));
        step("lu_after", idle, ex(0, 0, P_DEF));
        step("lu_r0", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), ex(0, 0, P_DEF));
        step("lu_rt", mk(3, 9, 1, 0, 1, 9, 0, 0, 0, 0), ex(0, 0, P_STALL));
        step("lu_rt_nu", mk(3, 9, 0, 0, 1, 9, 0, 0, 0, 0), ex(0, 0, P_DEF));
        step("lu_noload", mk(8, 0, 0, 0, 0, 8, 0, 0, 0, 0), ex(0, 0, P_DEF));
        // branch beats load-use
        step("br_lu", mk(8, 0, 0, 0, 1, 8, 1, 0, 0, 0), ex(0, 0, P_FLUSH));
        step("br_after", idle, ex(0, 0, P_DEF));
        step("jump", mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), ex(0, 0, P_JUMP));
        step("jump_lu", mk(8, 0, 0, 1, 1, 8, 0, 0, 0, 0), ex(0, 0, P_STALL));

        // memory wait: 5 frozen cycles, then ready
        step("mw_first", wait_v, ex(0, 0, P_FRZ));
        for (int i = 0; i < 4; i++) step("mw_hold", wait_v, ex(1, 0, P_FRZ));
        step("mw_ready", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), ex(1, 0, P_DEF));
        step("mw_done", idle, ex(0, 0, P_DEF));

        // watchdog: wait-state cycles 0..6 frozen, cycle 7 releases
        step("wd_first", wait_v, ex(0, 0, P_FRZ));
        for (int i = 0; i < TO - 1; i++) step("wd_hold", wait_v, ex(1, 0, P_FRZ));
        step("wd_fire", wait_v, ex(1, 0, P_DEF));
        step("wd_pulse", idle, ex(0, 1, P_DEF));
        step("wd_clear", idle, ex(0, 0, P_DEF));

        // exception drain: 2 cycles
        step("exc", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ex(0, 0, P_FLUSH));
        step("drain1", idle, ex(2, 0, P_FLUSH));
        step("drain2", idle, ex(2, 0, P_FLUSH));
        step("drain_end", idle, ex(0, 0, P_DEF));

        // second exception in the first drain cycle -> 3 drain cycles
        step("exc_a", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ex(0, 0, P_FLUSH));
        step("exc_b", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ex(2, 0, P_FLUSH));
        step("xdrain2", idle, ex(2, 0, P_FLUSH));
        step("xdrain3", idle, ex(2, 0, P_FLUSH));
        step("xdrain_end", idle, ex(0, 0, P_DEF));

        // memory freeze inside drain pauses the drain count
        step("exc_c", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ex(0, 0, P_FLUSH));
        step("fdrain1", idle, ex(2, 0, P_FLUSH));
        step("fdrain_frz", wait_v, ex(2, 0, P_FRZ));
        step("fdrain2", idle, ex(2, 0, P_FLUSH));
        step("fdrain_end", idle, ex(0, 0, P_DEF));

        // reset asserted in MEM_WAIT takes effect immediately
        step("rst_mw1", wait_v, ex(0, 0, P_FRZ));
        step("rst_mw2", wait_v, ex(1, 0, P_FRZ));
        reset = 1'b1;
        #2;
        chk("rst_async", {state, mem_timeout_err, outs}, ex(0, 0, P_DEF));
        $display("txn %-10s state=%0d err=%b outs=%b", "rst_async", state, mem_timeout_err, outs);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("rst_after", idle, ex(0, 0, P_DEF));
        step("final", idle, ex(0, 0, P_DEF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
